// File: rtl/uart_reg_bridge.sv
// rtl/uart_reg_bridge.sv - UART byte-stream command decoder driving a single-beat register bus
// Defining UART_BRIDGE_TIMEOUT_EN adds an inter-byte gap timer that aborts stalled frames.
module uart_reg_bridge #(
  parameter int ADDR_BYTES     = 1,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  input  logic                    rx_err,
  output logic                    rx_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  input  logic                    tx_ready,
  output logic                    reg_req,
  output logic                    reg_we,
  output logic [8*ADDR_BYTES-1:0] reg_addr,
  output logic [7:0]              reg_wdata,
  input  logic [7:0]              reg_rdata,
  input  logic                    reg_ack,
  output logic                    busy,
  output logic                    timeout
);
  localparam int AW = 8 * ADDR_BYTES;
  localparam logic [7:0] OP_WRITE   = 8'h57;
  localparam logic [7:0] OP_READ    = 8'h52;
  localparam logic [7:0] RESP_ACK   = 8'h4B;
  localparam logic [7:0] RESP_BADOP = 8'h3F;
  localparam logic [7:0] RESP_ERR   = 8'h45;

  if (ADDR_BYTES < 1 || ADDR_BYTES > 2 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("uart_reg_bridge: illegal ADDR_BYTES or TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_BUS, S_SEND
  } state_t;

  state_t state, state_nx;
  logic   rx_fire, tx_fire, ack_fire;
  logic   addr_cnt, last_addr, op_valid, gap_hit;

  // rx_ready/reg_req are registered images of the state, so they qualify the handshakes directly
  assign rx_fire   = rx_valid && rx_ready;
  assign tx_fire   = tx_valid && tx_ready;
  assign ack_fire  = reg_ack && reg_req;
  assign last_addr = (ADDR_BYTES == 1) || addr_cnt;
  assign op_valid  = (rx_data == OP_WRITE) || (rx_data == OP_READ);

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);
  logic [GW-1:0] gap_cnt;
  logic          receiving;

  assign receiving = (state == S_GET_ADDR) || (state == S_GET_DATA);
  assign gap_hit   = receiving && !rx_fire && (gap_cnt == GAP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      gap_cnt <= '0;
    else if (rx_fire || !receiving)
      gap_cnt <= '0;
    else if (gap_cnt != GAP_LAST)
      gap_cnt <= gap_cnt + 1'b1;
  end
`else
  assign gap_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:
        if (rx_fire) state_nx = (rx_err || !op_valid) ? S_SEND : S_GET_ADDR;
      S_GET_ADDR:
        if (rx_fire) begin
          if (rx_err)         state_nx = S_SEND;
          else if (last_addr) state_nx = reg_we ? S_GET_DATA : S_BUS;
        end else if (gap_hit) begin
          state_nx = S_IDLE;
        end
      S_GET_DATA:
        if (rx_fire)      state_nx = rx_err ? S_SEND : S_BUS;
        else if (gap_hit) state_nx = S_IDLE;
      S_BUS:
        if (ack_fire) state_nx = S_SEND;
      S_SEND:
        if (tx_fire) state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  // Handshake flags follow the next state so every output is a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready  <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      reg_req   <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      addr_cnt  <= 1'b0;
    end else begin
      rx_ready <= (state_nx == S_IDLE) || (state_nx == S_GET_ADDR) || (state_nx == S_GET_DATA);
      reg_req  <= (state_nx == S_BUS);
      tx_valid <= (state_nx == S_SEND);
      busy     <= (state_nx != S_IDLE);
      timeout  <= gap_hit;

      if (state != S_GET_ADDR) addr_cnt <= 1'b0;
      else if (rx_fire)        addr_cnt <= ~addr_cnt;

      if (rx_fire) begin
        if (rx_err) begin
          tx_data <= RESP_ERR;
        end else begin
          case (state)
            S_IDLE:
              if (op_valid) reg_we  <= (rx_data == OP_WRITE);
              else          tx_data <= RESP_BADOP;
            S_GET_ADDR: reg_addr  <= AW'({reg_addr, rx_data});
            S_GET_DATA: reg_wdata <= rx_data;
            default: ;
          endcase
        end
      end

      if (ack_fire) tx_data <= reg_we ? RESP_ACK : reg_rdata;
    end
  end
endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb/tb_uart_reg_bridge.sv - randomized frame traffic checked against a transaction-level model
module tb_uart_reg_bridge;
  localparam int AB = 2;
  localparam int TO = 100;
  localparam int AW = 8 * AB;
  localparam logic [7:0] OPW = 8'h57;
  localparam logic [7:0] OPR = 8'h52;
  localparam int P_IDLE = 0, P_RECV = 1, P_BUS = 2, P_SEND = 3;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic          rx_valid = 1'b0, rx_err = 1'b0, rx_ready;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_valid, tx_ready;
  logic [7:0]    tx_data;
  logic          reg_req, reg_we, reg_ack;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata, reg_rdata;
  logic          busy, timeout;

  uart_reg_bridge #(.ADDR_BYTES(AB), .TIMEOUT_CYCLES(TO)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [AW-1:0] addr; logic [7:0] wd; } bus_t;
  bus_t       bus_q[$];
  logic [7:0] resp_q[$];
  int         phase = P_IDLE;
  int         n_tests = 0, n_fail = 0;
  bit         chk_en = 0, resp_on = 1, txr_low = 0, rdata_force_en = 0;
  int         ack_force = -1;
  logic [7:0] rdata_force = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model's phase and expected bus/response queues
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("rx_ready", rx_ready, phase == P_IDLE || phase == P_RECV);
      check("reg_req", reg_req, phase == P_BUS);
      check("tx_valid", tx_valid, phase == P_SEND);
      check("busy", busy, phase != P_IDLE);
      check("timeout", timeout, 0);
      if (phase == P_BUS && bus_q.size() > 0) begin
        check("reg_we", reg_we, bus_q[0].we);
        check("reg_addr", reg_addr, bus_q[0].addr);
        if (bus_q[0].we) check("reg_wdata", reg_wdata, bus_q[0].wd);
      end
      if (phase == P_SEND && resp_q.size() > 0) begin
        check("tx_data", tx_data, resp_q[0]);
        if (tx_valid && tx_ready) begin
          void'(resp_q.pop_front());
          phase = P_IDLE;
        end
      end
    end
  end

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_ready = txr_low ? 1'b0 : ($urandom_range(0, 9) < 7);
    end
  end

  initial begin
    int d;
    reg_ack = 1'b0; reg_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (resp_on && reg_req === 1'b1 && bus_q.size() > 0) begin
        d = (ack_force >= 0) ? ack_force : $urandom_range(0, 3);
        repeat (d) begin @(posedge clk); #1; end
        reg_rdata = rdata_force_en ? rdata_force : 8'($urandom);
        reg_ack = 1'b1;
        @(posedge clk);
        resp_q.push_back(bus_q[0].we ? 8'h4B : reg_rdata);
        void'(bus_q.pop_front());
        phase = P_SEND;
        #1;
        reg_ack = 1'b0;
        check("ack_drops_req", reg_req, 0);
        check("ack_raises_tx", tx_valid, 1);
      end
    end
  end

  // Presents a byte from just after a rising edge; returns on the edge that accepts it
  task automatic send_byte(input logic [7:0] b, input logic err);
    int t;
    t = 0;
    rx_valid = 1'b1; rx_data = b; rx_err = err;
    @(negedge clk);
    while (rx_ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) check("rx_accept_bound", rx_ready, 1);
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [AW-1:0] addr, input logic [7:0] wd,
                            input int err_pos, input int max_gap);
    logic [7:0] bytes[$];
    bus_t e;
    bit done;
    done = 0;
    bytes.push_back(op);
    if (op == OPW || op == OPR) begin
      for (int i = AB - 1; i >= 0; i--) bytes.push_back(addr[8*i +: 8]);
      if (op == OPW) bytes.push_back(wd);
    end
    for (int i = 0; i < bytes.size() && !done; i++) begin
      send_byte(bytes[i], err_pos == i);
      if (err_pos == i) begin
        resp_q.push_back(8'h45); phase = P_SEND; done = 1;
      end else if (bytes.size() == 1) begin
        resp_q.push_back(8'h3F); phase = P_SEND; done = 1;
      end else if (i == bytes.size() - 1) begin
        e.we = (op == OPW); e.addr = addr; e.wd = wd;
        bus_q.push_back(e); phase = P_BUS; done = 1;
      end else begin
        phase = P_RECV;
      end
      #1;
      rx_valid = 1'b0; rx_err = 1'b0;
      if (!done) repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic raw_byte(input logic [7:0] b);
    send_byte(b, 1'b0);
    phase = P_RECV;
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx();
    int t;
    t = 0;
    while (tx_valid !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    check("tx_wait_bound", tx_valid, 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(phase == P_IDLE && bus_q.size() == 0 && resp_q.size() == 0) && t < 500) begin
      @(negedge clk); t++;
    end
    @(posedge clk); #1;
    check("idle_bound", busy, 0);
  endtask

  initial begin
    #800_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int kind, ep, len, k;
    logic [7:0] op;
    bit tx_seen;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_ready", rx_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_reg_req", reg_req, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    #1 check("rx_ready_before_edge", rx_ready, 0);
    @(posedge clk); #1;
    check("rx_ready_after_edge", rx_ready, 1);
    phase = P_IDLE;
    chk_en = 1;

    ack_force = 3;
    send_frame(OPW, 16'h003C, 8'hA5, -1, 0);
    check("wr_req", reg_req, 1);
    check("wr_we", reg_we, 1);
    check("wr_addr", reg_addr, 16'h003C);
    check("wr_wdata", reg_wdata, 8'hA5);
    check("wr_rx_ready", rx_ready, 0);
    wait_tx();
    check("wr_resp", tx_data, 8'h4B);
    wait_idle();
    ack_force = -1;

    txr_low = 1; rdata_force_en = 1; rdata_force = 8'h5A;
    send_frame(OPR, 16'h1234, 8'h00, -1, 0);
    check("rd_we", reg_we, 0);
    check("rd_addr", reg_addr, 16'h1234);
    wait_tx();
    repeat (10) begin
      @(negedge clk);
      check("rd_hold_valid", tx_valid, 1);
      check("rd_hold_data", tx_data, 8'h5A);
    end
    txr_low = 0; rdata_force_en = 0;
    wait_idle();

    send_frame(8'h00, 16'h0000, 8'h00, -1, 0);
    check("badop_tx", tx_valid, 1);
    check("badop_resp", tx_data, 8'h3F);
    check("badop_no_req", reg_req, 0);
    wait_idle();
    send_frame(OPR, 16'h0010, 8'h00, 1, 0);
    check("err_tx", tx_valid, 1);
    check("err_resp", tx_data, 8'h45);
    check("err_no_req", reg_req, 0);
    wait_idle();

    raw_byte(OPW);
    raw_byte(8'h00);
    raw_byte(8'h3C);
`ifdef UART_BRIDGE_TIMEOUT_EN
    chk_en = 0;
    k = 0; tx_seen = 0;
    while (timeout !== 1'b1 && k < 300) begin
      @(negedge clk); k++;
      if (tx_valid) tx_seen = 1;
    end
    check("timeout_latency", k, TO + 1);
    check("timeout_busy", busy, 0);
    @(negedge clk);
    check("timeout_width", timeout, 0);
    check("timeout_no_tx", tx_seen || tx_valid, 0);
    phase = P_IDLE;
    chk_en = 1;
    @(posedge clk); #1;
    send_frame(OPR, 16'h003C, 8'h00, -1, 0);
    check("after_timeout_addr", reg_addr, 16'h003C);
    wait_idle();
`else
    repeat (TO + 50) begin @(posedge clk); #1; end
    check("stall_busy", busy, 1);
    send_byte(8'hA5, 1'b0);
    bus_q.push_back('{we: 1'b1, addr: 16'h003C, wd: 8'hA5});
    phase = P_BUS;
    #1;
    rx_valid = 1'b0;
    check("stall_resume_wdata", reg_wdata, 8'hA5);
    wait_idle();
`endif

    for (int f = 0; f < 250; f++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
        send_frame(OPW, AW'($urandom), 8'($urandom), -1, $urandom_range(0, 2));
      end else if (kind <= 6) begin
        send_frame(OPR, AW'($urandom), 8'($urandom), -1, $urandom_range(0, 2));
      end else if (kind == 7) begin
        do op = 8'($urandom); while (op == OPW || op == OPR);
        send_frame(op, AW'($urandom), 8'($urandom), -1, $urandom_range(0, 2));
      end else begin
        op = $urandom_range(0, 1) ? OPW : OPR;
        len = 1 + AB + ((op == OPW) ? 1 : 0);
        ep = $urandom_range(0, len - 1);
        send_frame(op, AW'($urandom), 8'($urandom), ep, $urandom_range(0, 2));
      end
    end
    wait_idle();

    resp_on = 0;
    send_frame(OPW, 16'h0077, 8'h11, -1, 0);
    repeat (2) begin @(posedge clk); #1; end
    check("pre_reset_req", reg_req, 1);
    chk_en = 0;
    rst_n = 1'b0;
    #1;
    check("reset_req_drop", reg_req, 0);
    check("reset_busy", busy, 0);
    check("reset_tx", tx_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_q.delete(); resp_q.delete();
    phase = P_IDLE;
    @(posedge clk); #1;
    chk_en = 1;
    reg_ack = 1'b1;
    @(posedge clk); #1;
    reg_ack = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("stray_ack_no_tx", tx_valid, 0);
    resp_on = 1;
    send_frame(OPR, 16'hBEEF, 8'h00, -1, 0);
    check("post_reset_addr", reg_addr, 16'hBEEF);
    wait_idle();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
